fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIF FFT over a dual-port sample RAM for one butterfly unit.

---
 rtl/fft_stage_sequencer.sv | 144 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIF FFT driven through one butterfly unit.
// Each stage is N/2 reads, then a drain gap equal to the write-back delay.
module fft_stage_sequencer #(
  parameter  int N        = 64,
  parameter  int BFLY_LAT = 3,
  localparam int AW       = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] stage_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_a_o,
  output logic [AW-1:0] rd_addr_b_o,
  output logic [AW-2:0] tw_idx_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_a_o,
  output logic [AW-1:0] wr_addr_b_o
);

  localparam int D    = BFLY_LAT + 1;
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(D + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   stage_q, stage_d;
  logic [AW-2:0]   k_q, k_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            issue;
  logic            busy_d, done_d;
  logic [AW-1:0]   span, msk, kx, a_d, b_d;
  logic [AW-2:0]   jn, tw_d;
  wr_t [D-1:0]     wr_pipe_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        k_d     = '0;
        if (start_i) begin
          state_d = S_RUN;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        if (k_q == (AW-1)'(HALF - 1)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d   = k_q + 1'b1;
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == CW'(D - 1)) begin
          if (stage_q == AW'(AW - 1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
            issue   = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);

    // span is a power of two, so g/j split is a mask: a = (k with j cleared)*2 + j
    span = AW'(HALF) >> stage_d;
    msk  = span - 1'b1;
    kx   = {1'b0, k_d};
    jn   = k_d & msk[AW-2:0];
    a_d  = issue ? (((kx & ~msk) << 1) | (kx & msk)) : '0;
    b_d  = issue ? (a_d | span) : '0;
    tw_d = issue ? (jn << stage_d) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_idx_o    <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      rd_en_o     <= issue;
      rd_addr_a_o <= a_d;
      rd_addr_b_o <= b_d;
      tw_idx_o    <= tw_d;
    end
  end

  // Write-back pipe: D cycles covers RAM read latency plus butterfly latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_pipe_q <= '0;
    end else begin
      wr_pipe_q[0] <= '{en: rd_en_o, a: rd_addr_a_o, b: rd_addr_b_o};
      for (int i = 1; i < D; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
    end
  end

  assign stage_o     = stage_q;
  assign wr_en_o     = wr_pipe_q[D-1].en;
  assign wr_addr_a_o = wr_pipe_q[D-1].a;
  assign wr_addr_b_o = wr_pipe_q[D-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: N=8/BFLY_LAT=2 and N=64/BFLY_LAT=3 instances,
// expected read/write schedules queued from a division-based address model.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  logic rst, start, sel;
  always #5 clk = ~clk;

  logic       busy8, done8, rd8, wr8;
  logic [2:0] stage8, ra8, rb8, wa8, wb8;
  logic [1:0] tw8;
  logic       busy64, done64, rd64, wr64;
  logic [5:0] stage64, ra64, rb64, wa64, wb64;
  logic [4:0] tw64;
  logic       start8, start64;

  assign start8  = start & ~sel;
  assign start64 = start & sel;

  fft_stage_sequencer #(.N(8), .BFLY_LAT(2)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .busy_o(busy8), .done_o(done8),
    .stage_o(stage8), .rd_en_o(rd8), .rd_addr_a_o(ra8), .rd_addr_b_o(rb8),
    .tw_idx_o(tw8), .wr_en_o(wr8), .wr_addr_a_o(wa8), .wr_addr_b_o(wb8));

  fft_stage_sequencer #(.N(64), .BFLY_LAT(3)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .busy_o(busy64), .done_o(done64),
    .stage_o(stage64), .rd_en_o(rd64), .rd_addr_a_o(ra64), .rd_addr_b_o(rb64),
    .tw_idx_o(tw64), .wr_en_o(wr64), .wr_addr_a_o(wa64), .wr_addr_b_o(wb64));

  logic       m_busy, m_done, m_rd, m_wr;
  logic [7:0] m_stage, m_ra, m_rb, m_tw, m_wa, m_wb;

  always_comb begin
    if (sel) begin
      m_busy = busy64; m_done = done64; m_rd = rd64; m_wr = wr64;
      m_stage = 8'(stage64); m_ra = 8'(ra64); m_rb = 8'(rb64);
      m_tw = 8'(tw64); m_wa = 8'(wa64); m_wb = 8'(wb64);
    end else begin
      m_busy = busy8; m_done = done8; m_rd = rd8; m_wr = wr8;
      m_stage = 8'(stage8); m_ra = 8'(ra8); m_rb = 8'(rb8);
      m_tw = 8'(tw8); m_wa = 8'(wa8); m_wb = 8'(wb8);
    end
  end

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } ev_t;

  ev_t rq[$];
  ev_t wq[$];
  int  passed = 0;
  int  total  = 0;

  function automatic bit outs_zero();
    return m_busy === 1'b0 && m_done === 1'b0 && m_rd === 1'b0 && m_wr === 1'b0 &&
           m_stage === 8'd0 && m_ra === 8'd0 && m_rb === 8'd0 && m_tw === 8'd0 &&
           m_wa === 8'd0 && m_wb === 8'd0;
  endfunction

  // Full transform on the selected instance; every rd/wr is checked against the queued schedule.
  task automatic run_chk(input bit s64, input int n, input int lat, input int restart_at,
                         input bit done_restart, input string tag);
    int logn, d, span, lim, done_c, exp_done;
    bit busy_bad;
    ev_t e;
    logn = $clog2(n);
    d    = lat + 1;
    rq.delete();
    wq.delete();
    for (int s = 0; s < logn; s++) begin
      span = n >> (s + 1);
      for (int k = 0; k < n / 2; k++) begin
        e.cyc = s * (n / 2 + d) + k;
        e.a   = 2 * (k / span) * span + (k % span);
        e.b   = e.a + span;
        e.tw  = (k % span) * (1 << s);
        e.st  = s;
        rq.push_back(e);
        e.cyc = e.cyc + d;
        wq.push_back(e);
      end
    end
    exp_done = logn * (n / 2 + d);
    lim      = exp_done + 6;
    done_c   = -1;
    busy_bad = 1'b0;
    sel      = s64;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c <= lim; c++) begin
      if (c > 0) @(negedge clk);
      start = 1'b0;
      if (m_rd === 1'b1) begin
        total++;
        if (rq.size() == 0) begin
          $display("FAIL %s rd_unexpected cyc=%0d a=%0d b=%0d", tag, c, m_ra, m_rb);
        end else begin
          e = rq.pop_front();
          if (c != e.cyc || m_ra !== 8'(e.a) || m_rb !== 8'(e.b) || m_tw !== 8'(e.tw) ||
              m_stage !== 8'(e.st))
            $display("FAIL %s rd got cyc=%0d a=%0d b=%0d tw=%0d st=%0d want cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                     tag, c, m_ra, m_rb, m_tw, m_stage, e.cyc, e.a, e.b, e.tw, e.st);
          else passed++;
        end
      end
      if (m_wr === 1'b1) begin
        total++;
        if (wq.size() == 0) begin
          $display("FAIL %s wr_unexpected cyc=%0d a=%0d b=%0d", tag, c, m_wa, m_wb);
        end else begin
          e = wq.pop_front();
          if (c != e.cyc || m_wa !== 8'(e.a) || m_wb !== 8'(e.b))
            $display("FAIL %s wr got cyc=%0d a=%0d b=%0d want cyc=%0d a=%0d b=%0d",
                     tag, c, m_wa, m_wb, e.cyc, e.a, e.b);
          else passed++;
        end
      end
      if (m_done === 1'b1) begin
        if (done_c < 0) done_c = c;
        else begin
          total++;
          $display("FAIL %s done_repeat cyc=%0d first=%0d", tag, c, done_c);
        end
        if (done_restart) start = 1'b1;
      end
      if ((done_c < 0 || c == done_c) ? (m_busy !== 1'b1) : (m_busy !== 1'b0)) busy_bad = 1'b1;
      if (c == restart_at) start = 1'b1;
    end
    total++;
    if (done_c != exp_done) $display("FAIL %s done_latency got %0d want %0d", tag, done_c, exp_done);
    else passed++;
    total++;
    if (rq.size() != 0 || wq.size() != 0)
      $display("FAIL %s missing_ops got rd_left=%0d wr_left=%0d want 0", tag, rq.size(), wq.size());
    else passed++;
    total++;
    if (busy_bad) $display("FAIL %s busy_window got mismatch want high until done only", tag);
    else passed++;
    total++;
    if (m_stage !== 8'd0 || m_busy !== 1'b0)
      $display("FAIL %s idle_after got stage=%0d busy=%0b want 0 0", tag, m_stage, m_busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      total++;
      if (!outs_zero()) $display("FAIL reset_state inst=%0d got busy=%0b rd=%0b wr=%0b stage=%0d want all 0",
                                 i, m_busy, m_rd, m_wr, m_stage);
      else passed++;
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_stage_order();
    run_chk(1'b0, 8, 2, -1, 1'b1, "n8_run");
  endtask

  task automatic test_start_while_busy();
    run_chk(1'b1, 64, 3, 10, 1'b0, "n64_restart");
  endtask

  task automatic test_reset_abort();
    bit found, bad;
    int c;
    sel = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    c = 0;
    while (!found && c < 40) begin
      if (m_rd === 1'b1 && m_stage === 8'd1) found = 1'b1;
      else begin @(negedge clk); c++; end
    end
    total++;
    if (!found) $display("FAIL abort_reach_stage1 got timeout want stage1 read");
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!outs_zero()) $display("FAIL abort_outputs got busy=%0b rd=%0b wr=%0b stage=%0d want all 0",
                               m_busy, m_rd, m_wr, m_stage);
    else passed++;
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_wr !== 1'b0 || m_done !== 1'b0 || m_rd !== 1'b0 || m_busy !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL abort_quiet got activity after reset want none");
    else passed++;
    run_chk(1'b0, 8, 2, -1, 1'b0, "n8_after_abort");
  endtask

  task automatic test_back_to_back();
    run_chk(1'b0, 8, 2, -1, 1'b0, "n8_b2b_first");
    run_chk(1'b0, 8, 2, -1, 1'b0, "n8_b2b_second");
  endtask

  initial begin
    test_reset();
    test_stage_order();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
